// File: rtl/half_sub.sv
// Registered unsigned subtractor: Do = a - b (wrap or clamp-to-zero), Bo = borrow, sticky borrow flag.
// Latency: one clock from in_valid sampled high to out_valid high.
// Backpressure: none; accepts a new operation every cycle.
module half_sub #(
  parameter int WIDTH = 1,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] Do,
  output logic             Bo,
  output logic             out_valid,
  output logic             borrow_sticky
);

  // Per-bit signals of the two half-subtractor stages in each cell.
  logic [WIDTH-1:0] hs1_dif;  // first stage difference: a ^ b
  logic [WIDTH-1:0] hs1_bor;  // first stage borrow: ~a & b
  logic [WIDTH-1:0] hs2_bor;  // second stage borrow: ~(a ^ b) & br_in
  logic [WIDTH:0]   br;       // ripple borrow chain, br[0] tied low
  logic [WIDTH-1:0] diff;     // raw modular difference
  logic [WIDTH-1:0] diff_sat; // difference after optional clamp

  // Registered state and next-state.
  logic [WIDTH-1:0] do_q, do_d;
  logic             bo_q, bo_d;
  logic             out_valid_q, out_valid_d;
  logic             sticky_q, sticky_d;

  // Ripple chain of bit cells, each two cascaded half subtractors.
  always_comb begin
    hs1_dif = '0;
    hs1_bor = '0;
    hs2_bor = '0;
    diff    = '0;
    br      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hs1_dif[i] = a[i] ^ b[i];
      hs1_bor[i] = ~a[i] & b[i];
      diff[i]    = hs1_dif[i] ^ br[i];
      hs2_bor[i] = ~hs1_dif[i] & br[i];
      br[i+1]    = hs1_bor[i] | hs2_bor[i];
    end
  end

  // Clamp to zero on underflow when saturation is selected; borrow is still reported.
  always_comb begin
    diff_sat = diff;
    if ((SAT != 0) && br[WIDTH]) begin
      diff_sat = '0;
    end
  end

  // Next-state: capture only when in_valid so idle operand values never reach state.
  always_comb begin
    do_d        = do_q;
    bo_d        = bo_q;
    sticky_d    = sticky_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      do_d = diff_sat;
      bo_d = br[WIDTH];
    end
    // A borrow on this edge takes priority over a clear request.
    if (in_valid && br[WIDTH]) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; reset clears everything immediately and drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q        <= '0;
      bo_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      do_q        <= do_d;
      bo_q        <= bo_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign Do            = do_q;
  assign Bo            = bo_q;
  assign out_valid     = out_valid_q;
  assign borrow_sticky = sticky_q;

endmodule

// File: tb/tb_half_sub.sv
// Directed bench for half_sub in three configurations: WIDTH=1, WIDTH=8 wrap, WIDTH=8 clamp.
// Table-driven single-edge vectors followed by hand sequences for async reset.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next one.
module tb_half_sub;

  logic clk;
  logic rst_n;

  // WIDTH=1 instance
  logic       v1, clr1;
  logic [0:0] a1, b1, do1;
  logic       bo1, ov1, st1;
  // WIDTH=8 SAT=0 instance
  logic       v8w, clr8w;
  logic [7:0] a8w, b8w, do8w;
  logic       bo8w, ov8w, st8w;
  // WIDTH=8 SAT=1 instance
  logic       v8s, clr8s;
  logic [7:0] a8s, b8s, do8s;
  logic       bo8s, ov8s, st8s;

  int checks;
  int failures;

  half_sub #(.WIDTH(1), .SAT(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .clr_sticky(clr1),
    .Do(do1), .Bo(bo1), .out_valid(ov1), .borrow_sticky(st1)
  );

  half_sub #(.WIDTH(8), .SAT(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8w), .a(a8w), .b(b8w), .clr_sticky(clr8w),
    .Do(do8w), .Bo(bo8w), .out_valid(ov8w), .borrow_sticky(st8w)
  );

  half_sub #(.WIDTH(8), .SAT(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8s), .a(a8s), .b(b8s), .clr_sticky(clr8s),
    .Do(do8s), .Bo(bo8s), .out_valid(ov8s), .borrow_sticky(st8s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;   // 0: WIDTH=1, 1: WIDTH=8 wrap, 2: WIDTH=8 clamp
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] e_do;
    logic       e_bo;
    logic       e_ov;
    logic       e_st;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    v1 = 1'b0; clr1 = 1'b0; a1 = '0; b1 = '0;
    v8w = 1'b0; clr8w = 1'b0; a8w = '0; b8w = '0;
    v8s = 1'b0; clr8s = 1'b0; a8s = '0; b8s = '0;
  endtask

  task automatic check_outs(input int sel, input string name, input logic [7:0] e_do,
                            input logic e_bo, input logic e_ov, input logic e_st);
    logic [7:0] g_do;
    logic       g_bo, g_ov, g_st;
    case (sel)
      0:       begin g_do = {7'b0, do1}; g_bo = bo1;  g_ov = ov1;  g_st = st1;  end
      1:       begin g_do = do8w;        g_bo = bo8w; g_ov = ov8w; g_st = st8w; end
      default: begin g_do = do8s;        g_bo = bo8s; g_ov = ov8s; g_st = st8s; end
    endcase
    check({name, ".Do"},            g_do,        e_do);
    check({name, ".Bo"},            {7'b0, g_bo}, {7'b0, e_bo});
    check({name, ".out_valid"},     {7'b0, g_ov}, {7'b0, e_ov});
    check({name, ".borrow_sticky"}, {7'b0, g_st}, {7'b0, e_st});
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    idle_all();
    rst_n = 1'b0;

    // Expected values computed by hand from unsigned subtraction.
    vecs.push_back('{0, 1'b1, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0, "w1_00"});
    vecs.push_back('{0, 1'b1, 8'h0, 8'h1, 1'b0, 8'h1, 1'b1, 1'b1, 1'b1, "w1_01"});
    vecs.push_back('{0, 1'b1, 8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b1, 1'b1, "w1_10"});
    vecs.push_back('{0, 1'b1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b0, 1'b1, 1'b1, "w1_11"});
    vecs.push_back('{0, 1'b0, 8'h1, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1, "w1_hold"});
    vecs.push_back('{1, 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, "w8_00m01"});
    vecs.push_back('{1, 1'b1, 8'hA5, 8'h25, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, "w8_a5m25"});
    vecs.push_back('{1, 1'b1, 8'hA5, 8'h25, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, "w8_clr_nobor"});
    vecs.push_back('{1, 1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, "w8_clr_bor"});
    vecs.push_back('{1, 1'b1, 8'h7F, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "w8_eq_clr"});
    vecs.push_back('{1, 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, "w8_hold_load"});
    vecs.push_back('{1, 1'b0, 8'h37, 8'hC4, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, "w8_hold1"});
    vecs.push_back('{1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, "w8_hold2"});
    vecs.push_back('{1, 1'b0, 8'h01, 8'hFE, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, "w8_hold3"});
    vecs.push_back('{2, 1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "s8_10m20"});
    vecs.push_back('{2, 1'b1, 8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1, "s8_20m10"});
    vecs.push_back('{2, 1'b1, 8'hFF, 8'hFE, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, "s8_ffmfe"});
    vecs.push_back('{2, 1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "s8_00mff"});

    // Reset state, observed before any clock edge.
    #1;
    check_outs(0, "rst_w1", 8'h0, 1'b0, 1'b0, 1'b0);
    check_outs(1, "rst_w8", 8'h0, 1'b0, 1'b0, 1'b0);
    check_outs(2, "rst_s8", 8'h0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      idle_all();
      case (vecs[i].sel)
        0: begin
          v1 = vecs[i].vld; a1 = vecs[i].a[0:0]; b1 = vecs[i].b[0:0]; clr1 = vecs[i].clr;
        end
        1: begin
          v8w = vecs[i].vld; a8w = vecs[i].a; b8w = vecs[i].b; clr8w = vecs[i].clr;
        end
        default: begin
          v8s = vecs[i].vld; a8s = vecs[i].a; b8s = vecs[i].b; clr8s = vecs[i].clr;
        end
      endcase
      @(posedge clk);
      #1;
      check_outs(vecs[i].sel, vecs[i].name, vecs[i].e_do, vecs[i].e_bo, vecs[i].e_ov, vecs[i].e_st);
    end

    // Async reset between edges with a nonzero result and a pending op.
    idle_all();
    v8w = 1'b1; a8w = 8'h00; b8w = 8'h01;
    @(posedge clk);
    #1;
    check_outs(1, "ar_pre", 8'hFF, 1'b1, 1'b1, 1'b1);
    a8w = 8'h05; b8w = 8'h01;
    #3 rst_n = 1'b0;
    #1;
    check_outs(1, "ar_during", 8'h00, 1'b0, 1'b0, 1'b0);
    check_outs(2, "ar_during_s8", 8'h00, 1'b0, 1'b0, 1'b0);
    v8w = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs(1, "ar_no_stale", 8'h00, 1'b0, 1'b0, 1'b0);
    v8w = 1'b1; a8w = 8'h05; b8w = 8'h01;
    @(posedge clk);
    #1;
    check_outs(1, "ar_first_cap", 8'h04, 1'b0, 1'b1, 1'b0);
    idle_all();
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
